// File: rtl/accel_axis_scanner_if.sv
// Bus between the axis scanner, the SPI reader and the host command handler.
// Signal names follow the reader/host pins they replace.
interface accel_axis_scanner_if;
  logic [15:0] iDATA;
  logic [1:0]  oDIMENSION;
  logic        iSNAP_REQ;
  logic        oSNAP_ACK;
  logic [15:0] oX;
  logic [15:0] oY;
  logic [15:0] oZ;
  logic [2:0]  oFRESH;
  logic [7:0]  oSCAN_CNT;

  modport master (
    input  iDATA,
    input  iSNAP_REQ,
    output oDIMENSION,
    output oSNAP_ACK,
    output oX,
    output oY,
    output oZ,
    output oFRESH,
    output oSCAN_CNT
  );

  modport slave (
    output iDATA,
    output iSNAP_REQ,
    input  oDIMENSION,
    input  oSNAP_ACK,
    input  oX,
    input  oY,
    input  oZ,
    input  oFRESH,
    input  oSCAN_CNT
  );
endinterface

// File: rtl/accel_axis_scanner.sv
// Round-robin X/Y/Z scanner with tear-checked capture and coherent snapshots.
// Define ACCEL_SCAN_AVG_EN for a 4-sample moving average per axis.
module accel_axis_scanner #(
  parameter int SETTLE_CYCLES = 2048
) (
  input logic                  iCLK,
  input logic                  iRSTN,
  accel_axis_scanner_if.master bus
);

  typedef enum logic [1:0] {
    S_SEL,
    S_SETTLE,
    S_CAP0,
    S_CAP1
  } state_e;

  localparam logic [11:0] RELOAD =
    12'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [1:0]  dim_q, dim_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] live_q [3];
  logic [15:0] live_d [3];
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [15:0] z_q, z_d;
  logic [2:0]  fresh_q, fresh_d;
  logic [7:0]  scan_q, scan_d;
  logic        req_q, req_d;
  logic        snap_q, snap_d;
  logic        ack_q, ack_d;
  logic        wr;

`ifdef ACCEL_SCAN_AVG_EN
  logic signed [17:0] sum_q [3];
  logic signed [17:0] sum_d [3];
  logic [15:0] hist_q [3][4];
  logic [15:0] hist_d [3][4];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dim_d   = dim_q;
    hold_d  = hold_q;
    live_d  = live_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    fresh_d = fresh_q;
    scan_d  = scan_q;
    wr      = 1'b0;
`ifdef ACCEL_SCAN_AVG_EN
    sum_d   = sum_q;
    hist_d  = hist_q;
`endif
    req_d  = bus.iSNAP_REQ;
    snap_d = bus.iSNAP_REQ & ~req_q;
    ack_d  = snap_q;

    // Snapshot reads pre-write live values
    if (snap_q) begin
      x_d     = live_q[0];
      y_d     = live_q[1];
      z_d     = live_q[2];
      fresh_d = 3'b000;
    end

    unique case (state_q)
      S_SEL: begin
        cnt_d   = RELOAD;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == 12'd0) begin
          state_d = S_CAP0;
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      S_CAP0: begin
        hold_d  = bus.iDATA;
        state_d = S_CAP1;
      end
      S_CAP1: begin
        if (bus.iDATA == hold_q) begin
          wr      = 1'b1;
          state_d = S_SEL;
          if (dim_q == 2'd2) begin
            dim_d  = 2'd0;
            scan_d = scan_q + 8'd1;
          end else begin
            dim_d = dim_q + 2'd1;
          end
        end else begin
          // Torn read across the reader's clock domain
          cnt_d   = RELOAD;
          state_d = S_SETTLE;
        end
      end
    endcase

    for (int a = 0; a < 3; a++) begin
      if (wr && dim_q == 2'(a)) begin
        fresh_d[a] = 1'b1;
`ifdef ACCEL_SCAN_AVG_EN
        sum_d[a] = sum_q[a]
                 + 18'(signed'(hold_q))
                 - 18'(signed'(hist_q[a][3]));
        hist_d[a][3] = hist_q[a][2];
        hist_d[a][2] = hist_q[a][1];
        hist_d[a][1] = hist_q[a][0];
        hist_d[a][0] = hold_q;
        live_d[a]    = sum_d[a][17:2];
`else
        live_d[a] = hold_q;
`endif
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state_q <= S_SEL;
      cnt_q   <= '0;
      dim_q   <= '0;
      hold_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      fresh_q <= '0;
      scan_q  <= '0;
      req_q   <= 1'b0;
      snap_q  <= 1'b0;
      ack_q   <= 1'b0;
      for (int a = 0; a < 3; a++) begin
        live_q[a] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dim_q   <= dim_d;
      hold_q  <= hold_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      fresh_q <= fresh_d;
      scan_q  <= scan_d;
      req_q   <= req_d;
      snap_q  <= snap_d;
      ack_q   <= ack_d;
      live_q  <= live_d;
    end
  end

`ifdef ACCEL_SCAN_AVG_EN
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      for (int a = 0; a < 3; a++) begin
        sum_q[a] <= '0;
        for (int k = 0; k < 4; k++) begin
          hist_q[a][k] <= '0;
        end
      end
    end else begin
      sum_q  <= sum_d;
      hist_q <= hist_d;
    end
  end
`endif

  assign bus.oDIMENSION = dim_q;
  assign bus.oSNAP_ACK  = ack_q;
  assign bus.oX         = x_q;
  assign bus.oY         = y_q;
  assign bus.oZ         = z_q;
  assign bus.oFRESH     = fresh_q;
  assign bus.oSCAN_CNT  = scan_q;

endmodule

// File: tb/tb_accel_axis_scanner.sv
// Bench for accel_axis_scanner: cycle reference model driven by axis timing,
// directed scenarios plus randomized data and snapshot traffic.
module tb_accel_axis_scanner;

  localparam int SC  = 8;
  localparam int PER = SC + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  accel_axis_scanner_if bus ();

  accel_axis_scanner #(
    .SETTLE_CYCLES(SC)
  ) dut (
    .iCLK (clk),
    .iRSTN(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] val [3];
  logic [15:0] m_live [3];
  logic [15:0] m_x, m_y, m_z;
  logic [2:0]  m_fresh;
  logic [7:0]  m_scan;
  logic [15:0] m_hold;
  logic        m_pend, m_prev, m_ack;
  int          m_axis;
  int          m_rem;
  int          m_sum [3];
  int          m_hist [3][4];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] avg_of(int s);
    if (s >= 0) return 16'(s / 4);
    return 16'(-((-s + 3) / 4));
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 3; a++) begin
      m_live[a] = '0;
      m_sum[a]  = 0;
      for (int k = 0; k < 4; k++) m_hist[a][k] = 0;
    end
    m_x = '0; m_y = '0; m_z = '0;
    m_fresh = '0; m_scan = '0; m_hold = '0;
    m_pend = 0; m_prev = 0; m_ack = 0;
    m_axis = 0;
    m_rem  = PER;
  endtask

  task automatic commit(int a, logic [15:0] din);
`ifdef ACCEL_SCAN_AVG_EN
    m_sum[a] = m_sum[a] + int'($signed(din))
             - m_hist[a][3];
    for (int k = 3; k > 0; k--)
      m_hist[a][k] = m_hist[a][k-1];
    m_hist[a][0] = int'($signed(din));
    m_live[a] = avg_of(m_sum[a]);
`else
    m_live[a] = din;
`endif
    m_fresh[a] = 1'b1;
    if (m_axis == 2) begin
      m_axis = 0;
      m_scan = m_scan + 8'd1;
    end else begin
      m_axis = m_axis + 1;
    end
  endtask

  // One clock edge of the reference: m_rem counts edges to the write
  task automatic model_step();
    logic [15:0] din;
    logic        req;
    din = bus.iDATA;
    req = bus.iSNAP_REQ;
    m_ack = m_pend;
    if (m_pend) begin
      m_x = m_live[0];
      m_y = m_live[1];
      m_z = m_live[2];
      m_fresh = 3'b000;
    end
    m_pend = req && !m_prev;
    m_prev = req;
    if (m_rem == 1) begin
      if (din == m_hold) begin
        commit(m_axis, din);
        m_rem = PER;
      end else begin
        m_rem = PER - 1;
      end
    end else begin
      if (m_rem == 2) m_hold = din;
      m_rem--;
    end
  endtask

  task automatic check_all();
    chk("dim", 32'(bus.oDIMENSION), 32'(m_axis));
    chk("ack", 32'(bus.oSNAP_ACK), 32'(m_ack));
    chk("x", 32'(bus.oX), 32'(m_x));
    chk("y", 32'(bus.oY), 32'(m_y));
    chk("z", 32'(bus.oZ), 32'(m_z));
    chk("fresh", 32'(bus.oFRESH), 32'(m_fresh));
    chk("scan", 32'(bus.oSCAN_CNT), 32'(m_scan));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_all();
    bus.iDATA = val[m_axis];
  endtask

  task automatic snap_pulse();
    bus.iSNAP_REQ = 1'b1;
    tick();
    bus.iSNAP_REQ = 1'b0;
    tick();
  endtask

  initial begin
    int cnt;
    int acks;
    int first;
    logic [15:0] prevz;

    bus.iSNAP_REQ = 1'b0;
    val[0] = 16'h0123;
    val[1] = 16'hFF80;
    val[2] = 16'h4000;
    bus.iDATA = val[0];
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Basic scan and first snapshot
    repeat (40) tick();
    snap_pulse();
    chk("s1_ack", 32'(bus.oSNAP_ACK), 32'd1);
    chk("s1_fresh", 32'(bus.oFRESH), 32'd0);
    chk("s1_scan", 32'(bus.oSCAN_CNT), 32'd1);
`ifndef ACCEL_SCAN_AVG_EN
    chk("s1_x", 32'(bus.oX), 32'h0123);
    chk("s1_y", 32'(bus.oY), 32'hFF80);
    chk("s1_z", 32'(bus.oZ), 32'h4000);
`endif

    // Tear on Y between CAP0 and CAP1
    for (int i = 0; i < 100 &&
         !(m_axis == 1 && m_rem == 1); i++) tick();
    chk("wait_y_cap1",
        32'(m_axis == 1 && m_rem == 1), 32'd1);
    val[1] = val[1] ^ 16'h00FF;
    bus.iDATA = val[1];
    cnt = 0;
    for (int i = 0; i < 40 &&
         bus.oDIMENSION == 2'd1; i++) begin
      tick();
      cnt++;
    end
    chk("tear_len", 32'(cnt), 32'(1 + SC + 2));
    snap_pulse();
`ifndef ACCEL_SCAN_AVG_EN
    chk("tear_y", 32'(bus.oY), 32'(val[1]));
`endif

    // Level held high gives one ack
    bus.iSNAP_REQ = 1'b1;
    acks = 0;
    first = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (bus.oSNAP_ACK) begin
        acks++;
        if (first < 0) first = i;
      end
    end
    chk("hold_acks", 32'(acks), 32'd1);
    chk("hold_lat", 32'(first), 32'd2);
    bus.iSNAP_REQ = 1'b0;
    tick();

    // Snapshot lands on the Z write edge
    for (int i = 0; i < 100 &&
         !(m_axis == 2 && m_rem >= PER - 1); i++)
      tick();
    chk("wait_z_sel",
        32'(m_axis == 2 && m_rem >= PER - 1), 32'd1);
    val[2] = val[2] ^ 16'h5A5A;
    bus.iDATA = val[2];
    for (int i = 0; i < 40 && m_rem != 2; i++) tick();
    chk("wait_z_cap0", 32'(m_rem), 32'd2);
    prevz = m_live[2];
    bus.iSNAP_REQ = 1'b1;
    tick();
    tick();
    chk("coin_ack", 32'(bus.oSNAP_ACK), 32'd1);
    chk("coin_z", 32'(bus.oZ), 32'(prevz));
    chk("coin_fresh", 32'(bus.oFRESH), 32'b100);
    bus.iSNAP_REQ = 1'b0;
    tick();

    // Random data changes and snapshot traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0)
        bus.iSNAP_REQ = ~bus.iSNAP_REQ;
      if ($urandom_range(0, 29) == 0) begin
        val[$urandom_range(0, 2)] = 16'($urandom);
        bus.iDATA = val[m_axis];
      end
      tick();
    end
    bus.iSNAP_REQ = 1'b0;
    tick();

    // Asynchronous reset in the middle of Z settle
    for (int i = 0; i < 100 &&
         !(m_axis == 2 && m_rem == 6); i++) tick();
    chk("wait_z_settle",
        32'(m_axis == 2 && m_rem == 6), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dim", 32'(bus.oDIMENSION), 32'd0);
    chk("rst_x", 32'(bus.oX), 32'd0);
    chk("rst_y", 32'(bus.oY), 32'd0);
    chk("rst_z", 32'(bus.oZ), 32'd0);
    chk("rst_fresh", 32'(bus.oFRESH), 32'd0);
    chk("rst_scan", 32'(bus.oSCAN_CNT), 32'd0);
    chk("rst_ack", 32'(bus.oSNAP_ACK), 32'd0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (PER) tick();
    chk("rst_first_dim", 32'(bus.oDIMENSION), 32'd1);
    chk("rst_first_fresh", 32'(bus.oFRESH), 32'b001);
    snap_pulse();
`ifndef ACCEL_SCAN_AVG_EN
    chk("rst_first_x", 32'(bus.oX), 32'(val[0]));
`endif

`ifdef ACCEL_SCAN_AVG_EN
    // Averaging ramp and negative convergence
    #2 rst_n = 1'b0;
    model_reset();
    val[0] = 16'h0100;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      repeat (3 * PER - 2) tick();
      snap_pulse();
      chk("avg_ramp", 32'(bus.oX),
          32'(16'h0040 * k));
    end
    val[0] = 16'hFFFC;
    repeat (4 * 3 * PER) tick();
    snap_pulse();
    chk("avg_neg", 32'(bus.oX), 32'hFFFC);
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
